alu_dec_stage: RTL and testbench

ALU_DEC_STAGE -- requirements
Module: alu_dec_stage

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_sel_dec.sv | 83 ++++++++
 rtl/alu_dec_stage.sv | 117 +++++++++++
 tb/tb_alu_dec_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select codes, opcode constants and decode-stage FSM encoding
package alu_pkg;

    localparam logic [3:0] SEL_AND       = 4'b0000;
    localparam logic [3:0] SEL_OR        = 4'b0001;
    localparam logic [3:0] SEL_XOR       = 4'b1001;
    localparam logic [3:0] SEL_ADD       = 4'b0010;
    localparam logic [3:0] SEL_SUB       = 4'b0011;
    localparam logic [3:0] SEL_SLTU      = 4'b0100;
    localparam logic [3:0] SEL_SLT       = 4'b1011;
    localparam logic [3:0] SEL_PASS_B    = 4'b0101;
    localparam logic [3:0] SEL_ADD_SHL12 = 4'b0111;
    localparam logic [3:0] SEL_SLL       = 4'b1000;
    localparam logic [3:0] SEL_SRL       = 4'b1100;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [3:0]  alu_sel;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } dec_entry_t;

    // Shared by register and immediate forms; shifts map SRA slots to SRL and are rejected by funct7.
    function automatic logic [3:0] funct3_sel(input logic [2:0] funct3);
        logic [3:0] sel;
        case (funct3)
            3'b000:  sel = SEL_ADD;
            3'b001:  sel = SEL_SLL;
            3'b010:  sel = SEL_SLT;
            3'b011:  sel = SEL_SLTU;
            3'b100:  sel = SEL_XOR;
            3'b101:  sel = SEL_SRL;
            3'b110:  sel = SEL_OR;
            default: sel = SEL_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_sel_dec.sv
// rtl/alu_sel_dec.sv - combinational instruction decoder for the ALU stage
// ALU_DEC_ILLEGAL_EN: when defined, illegal is reported; otherwise tied 0.
module alu_sel_dec (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [3:0]  alu_sel,
    output logic [4:0]  rd,
    output logic        wen,
    output logic        illegal
);
    import alu_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        legal   = 1'b1;
        op_a    = 32'd0;
        op_b    = 32'd0;
        alu_sel = SEL_ADD;
        case (opcode)
            OPC_OP: begin
                op_a = rs1_data;
                op_b = rs2_data;
                if (funct7 == F7_BASE) begin
                    alu_sel = funct3_sel(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_sel = SEL_SUB;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                op_a    = rs1_data;
                op_b    = {{20{instr[31]}}, instr[31:20]};
                alu_sel = funct3_sel(funct3);
                // Shift-immediates carry funct7 in the upper immediate bits; only logical shifts are legal.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    op_b = {27'd0, instr[24:20]};
                    if (funct7 != F7_BASE) begin
                        legal = 1'b0;
                    end
                end
            end
            OPC_LUI: begin
                alu_sel = SEL_PASS_B;
                op_b    = {instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                alu_sel = SEL_ADD_SHL12;
                op_a    = pc;
                op_b    = {12'd0, instr[31:12]};
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            op_a    = 32'd0;
            op_b    = 32'd0;
            alu_sel = SEL_ADD;
        end
    end

    assign rd  = instr[11:7];
    assign wen = legal && (instr[11:7] != 5'd0);

`ifdef ALU_DEC_ILLEGAL_EN
    assign illegal = ~legal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_dec_stage.sv
// rtl/alu_dec_stage.sv - decode stage with 2-entry skid buffer feeding the ALU
// ALU_DEC_ILLEGAL_EN (in alu_sel_dec) controls out_illegal reporting.
module alu_dec_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [3:0]  out_alu_sel,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_illegal
);
    import alu_pkg::*;

    logic [31:0] dec_op_a;
    logic [31:0] dec_op_b;
    logic [3:0]  dec_alu_sel;
    logic [4:0]  dec_rd;
    logic        dec_wen;
    logic        dec_illegal;
    dec_entry_t  dec_w;

    logic [1:0]  state_q, state_d;
    logic        in_ready_q, in_ready_d;
    dec_entry_t  head_q, head_d;
    dec_entry_t  tail_q, tail_d;
    logic        accept;
    logic        drain;

    alu_sel_dec u_dec (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .op_a     (dec_op_a),
        .op_b     (dec_op_b),
        .alu_sel  (dec_alu_sel),
        .rd       (dec_rd),
        .wen      (dec_wen),
        .illegal  (dec_illegal)
    );

    assign dec_w = '{op_a: dec_op_a, op_b: dec_op_b, alu_sel: dec_alu_sel,
                     rd: dec_rd, wen: dec_wen, illegal: dec_illegal};

    assign accept = in_valid & in_ready_q & ~flush;
    assign drain  = (state_q != ST_EMPTY) & out_ready & ~flush;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_d  = dec_w;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    head_d = dec_w;
                end else if (accept) begin
                    state_d = ST_TWO;
                    tail_d  = dec_w;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d = ST_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        // Registered from next state so in_ready never depends combinationally on out_ready.
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_op_a    = head_q.op_a;
    assign out_op_b    = head_q.op_b;
    assign out_alu_sel = head_q.alu_sel;
    assign out_rd      = head_q.rd;
    assign out_wen     = head_q.wen;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_dec_stage.sv
// tb/tb_alu_dec_stage.sv - scoreboard bench for alu_dec_stage
module tb_alu_dec_stage;

`ifdef ALU_DEC_ILLEGAL_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [3:0]  out_alu_sel;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_dec_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op_a    (out_op_a),
        .out_op_b    (out_op_b),
        .out_alu_sel (out_alu_sel),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                                input logic [4:0] rd, input logic wen, input logic ill);
        exp_t e;
        e = '{a: a, b: b, sel: sel, rd: rd, wen: wen, ill: ill};
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [4:0] rd);
        return mk(32'd0, 32'd0, 4'b0010, rd, 1'b0, EXP_ILL);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Must be called at posedge+1; the offer is held until in_ready is seen.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input exp_t e);
        bit done;
        done        = 1'b0;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_valid    = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: instr %h never accepted", instr);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: out_valid=1 with rd=%0d but nothing expected", out_rd);
            end else begin
                if ({out_op_a, out_op_b, out_alu_sel, out_rd, out_wen, out_illegal} !== sb_q[0]) begin
                    n_err++;
                    $display("FAIL scoreboard: got a=%h b=%h sel=%b rd=%0d wen=%b ill=%b, expected a=%h b=%h sel=%b rd=%0d wen=%b ill=%b",
                             out_op_a, out_op_b, out_alu_sel, out_rd, out_wen, out_illegal,
                             sb_q[0].a, sb_q[0].b, sb_q[0].sel, sb_q[0].rd, sb_q[0].wen, sb_q[0].ill);
                end
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'd0;
        in_pc       = 32'd0;
        in_rs1_data = 32'd0;
        in_rs2_data = 32'd0;
        out_ready   = 1'b0;

        #3;
        chk("reset_out_valid", 80'(out_valid), 80'd0);
        chk("reset_in_ready", 80'(in_ready), 80'd0);
        chk("reset_data", 80'({out_op_a, out_op_b, out_rd, out_wen, out_illegal}), 80'd0);
        chk("reset_sel", 80'(out_alu_sel), 80'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 80'(in_ready), 80'd0);
        @(posedge clk);
        #1;
        chk("ready_after_reset", 80'(in_ready), 80'd1);

        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0));
        @(negedge clk);
        chk("latency_out_valid", 80'(out_valid), 80'd1);
        @(negedge clk);
        chk("drained_empty", 80'(out_valid), 80'd0);
        @(posedge clk);
        #1;

        send(32'h402081B3, 32'h0, 32'd20, 32'd6, mk(32'd20, 32'd6, 4'b0011, 5'd3, 1'b1, 1'b0));
        send(32'h4020D193, 32'h0, 32'h80, 32'd1, mk_ill(5'd3));
        send(32'h123452B7, 32'h0, 32'h55, 32'h66, mk(32'd0, 32'h12345000, 4'b0101, 5'd5, 1'b1, 1'b0));
        send(32'h12345317, 32'h100, 32'h55, 32'h66, mk(32'h100, 32'h00012345, 4'b0111, 5'd6, 1'b1, 1'b0));
        send(32'hFFF0E213, 32'h0, 32'h1234, 32'd0, mk(32'h1234, 32'hFFFFFFFF, 4'b0001, 5'd4, 1'b1, 1'b0));
        send(32'h00509393, 32'h0, 32'd3, 32'd0, mk(32'd3, 32'd5, 4'b1000, 5'd7, 1'b1, 1'b0));
        send(32'h01F0D413, 32'h0, 32'h80000000, 32'd0, mk(32'h80000000, 32'd31, 4'b1100, 5'd8, 1'b1, 1'b0));
        send(32'h0020A4B3, 32'h0, 32'hFFFFFFFF, 32'd1, mk(32'hFFFFFFFF, 32'd1, 4'b1011, 5'd9, 1'b1, 1'b0));
        send(32'h0020C533, 32'h0, 32'hF0, 32'h0F, mk(32'hF0, 32'h0F, 4'b1001, 5'd10, 1'b1, 1'b0));
        send(32'h8000B593, 32'h0, 32'd9, 32'd0, mk(32'd9, 32'hFFFFF800, 4'b0100, 5'd11, 1'b1, 1'b0));
        send(32'h0FF0F613, 32'h0, 32'hABCD, 32'd0, mk(32'hABCD, 32'hFF, 4'b0000, 5'd12, 1'b1, 1'b0));
        send(32'h000000EF, 32'h0, 32'd1, 32'd2, mk_ill(5'd1));
        send(32'h4020D1B3, 32'h0, 32'd1, 32'd2, mk_ill(5'd3));
        send(32'h022081B3, 32'h0, 32'd1, 32'd2, mk_ill(5'd3));
        repeat (3) @(posedge clk);
        #1;
        chk("stream_drained", 80'(sb_q.size()), 80'd0);

        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'b0010, 5'd3, 1'b1, 1'b0));
        send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'b0011, 5'd3, 1'b1, 1'b0));
        in_instr    = 32'h0020C533;
        in_rs1_data = 32'h1;
        in_rs2_data = 32'h3;
        in_valid    = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_ready", 80'(in_ready), 80'd0);
            chk("stall_out_valid", 80'(out_valid), 80'd1);
            chk("stall_accepted", 80'(sb_q.size()), 80'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0020C533, 32'h0, 32'h1, 32'h3, mk(32'h1, 32'h3, 4'b1001, 5'd10, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("stall_drained", 80'(sb_q.size()), 80'd0);

        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd3, 32'd4, mk(32'd3, 32'd4, 4'b0010, 5'd3, 1'b1, 1'b0));
        send(32'h0020C533, 32'h0, 32'd5, 32'd6, mk(32'd5, 32'd6, 4'b1001, 5'd10, 1'b1, 1'b0));
        in_instr = 32'h123452B7;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("flush_two_out_valid", 80'(out_valid), 80'd0);
        chk("flush_two_in_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        chk("flush_two_nothing", 80'(out_valid), 80'd0);
        @(posedge clk);
        #1;

        send(32'h002081B3, 32'h0, 32'd8, 32'd9, mk(32'd8, 32'd9, 4'b0010, 5'd3, 1'b1, 1'b0));
        in_instr = 32'h123452B7;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("flush_one_out_valid", 80'(out_valid), 80'd0);
        @(posedge clk);
        #1;

        send(32'h00100013, 32'h0, 32'd0, 32'd0, mk(32'd0, 32'd1, 4'b0010, 5'd0, 1'b0, 1'b0));
        send(32'h002081B3, 32'h0, 32'd11, 32'd12, mk(32'd11, 32'd12, 4'b0010, 5'd3, 1'b1, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 80'(out_valid), 80'd0);
        chk("midreset_in_ready", 80'(in_ready), 80'd0);
        chk("midreset_data", 80'({out_op_a, out_op_b, out_alu_sel, out_rd, out_wen}), 80'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 80'(in_ready), 80'd1);
        chk("post_reset_out_valid", 80'(out_valid), 80'd0);

        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd21, 32'd22, mk(32'd21, 32'd22, 4'b0010, 5'd3, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 80'(sb_q.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
